// File: rtl/rom_seq_pkg.sv
// Shared defaults and state encoding for the ROM address sequencer.
package rom_seq_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DIV_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/rom_addr_seq_if.sv
// Control and ROM-side signals of the address sequencer.
interface rom_addr_seq_if #(
    parameter int ADDR_W = 8,
    parameter int DIV_W  = 16
);
    logic              start;
    logic              stop;
    logic [DIV_W-1:0]  div;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              wrap;
    logic              busy;

    modport master (
        output start, stop, div,
        input  en, addr, wrap, busy
    );

    modport slave (
        input  start, stop, div,
        output en, addr, wrap, busy
    );
endinterface

// File: rtl/rom_addr_seq_tick_div.sv
// Rate prescaler: counts 0..lim_i while running and ticks on the terminal count.
module tick_div
    import rom_seq_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] lim_i,
    output logic             tick_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = run_i && (cnt_q == lim_i);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rom_addr_seq.sv
// ROM address sequencer: steps addr through one full period per 2**ADDR_W
// prescaled steps, with start/stop control and period-aligned rate reloads.
module rom_addr_seq
    import rom_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic          clk,
    input  logic          rst,
    rom_addr_seq_if.slave bus
);
    seq_state_e        st_q, st_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              wrap_q, wrap_d;
    logic              tick, clr, run, last_step;

    tick_div #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .run_i  (run),
        .lim_i  (div_q),
        .tick_o (tick)
    );

    assign last_step = tick && (addr_q == {ADDR_W{1'b1}});

    always_comb begin
        st_d   = st_q;
        addr_d = addr_q;
        div_d  = div_q;
        wrap_d = 1'b0;
        clr    = 1'b0;
        run    = 1'b0;

        unique case (st_q)
            IDLE: begin
                if (bus.start) begin
                    st_d   = RUN;
                    addr_d = '0;
                    clr    = 1'b1;
                    div_d  = bus.div;
                end
            end
            RUN, DRAIN: begin
                run = 1'b1;
                if (tick) begin
                    addr_d = addr_q + 1'b1;
                end
                // The rate only reloads on the period boundary so a change never tears a period.
                if (last_step) begin
                    wrap_d = 1'b1;
                    div_d  = bus.div;
                end
                if (st_q == RUN) begin
                    if (bus.stop) begin
                        st_d = DRAIN;
                    end
                end else if (bus.start && !bus.stop) begin
                    st_d = RUN;
                end else if (last_step) begin
                    st_d = IDLE;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase

        en_d   = (st_d != IDLE);
        busy_d = (st_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            addr_q <= '0;
            div_q  <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            addr_q <= addr_d;
            div_q  <= div_d;
            en_q   <= en_d;
            busy_q <= busy_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.en   = en_q;
    assign bus.busy = busy_q;
    assign bus.wrap = wrap_q;
    assign bus.addr = addr_q;
endmodule

// File: tb/tb_rom_addr_seq.sv
// Scoreboard bench for rom_addr_seq against a cycle-position reference model.
module tb_rom_addr_seq;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NADDR = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_addr_seq_if #(.ADDR_W(AW), .DIV_W(DW)) bus ();

    rom_addr_seq #(.ADDR_W(AW), .DIV_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected sample layout: {en, busy, wrap, addr}
    typedef logic [AW+2:0] exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Model: mode 0=idle 1=run 2=drain; t = cycles elapsed in the current period.
    int m_mode = 0;
    int m_t    = 0;
    int m_dq   = 0;

    function automatic int m_addr();
        return m_t / (m_dq + 1);
    endfunction

    function automatic exp_t model_step(input logic s, input logic p, input int d);
        logic w;
        w = 1'b0;
        if (m_mode == 0) begin
            if (s) begin
                m_mode = 1;
                m_t    = 0;
                m_dq   = d;
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == NADDR * (m_dq + 1)) begin
                m_t  = 0;
                w    = 1'b1;
                m_dq = d;
            end
            if (m_mode == 1) begin
                if (p) m_mode = 2;
            end else if (s && !p) begin
                m_mode = 1;
            end else if (w) begin
                m_mode = 0;
            end
        end
        return {(m_mode != 0), (m_mode != 0), w, AW'(m_addr())};
    endfunction

    task automatic cyc(input logic s, input logic p, input int d);
        @(negedge clk);
        bus.start = s;
        bus.stop  = p;
        bus.div   = DW'(d);
        exp_q.push_back(model_step(s, p, d));
    endtask

    task automatic check_bound(input string name, input bit ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: model target not reached within cycle budget (reached=0, required=1)", name);
        end
    endtask

    task automatic run_until_addr(input int a, input int d, input int limit);
        int k;
        k = 0;
        while (m_addr() != a && k < limit) begin
            cyc(1'b0, 1'b0, d);
            k++;
        end
        check_bound($sformatf("reach_addr_%0d", a), m_addr() == a);
    endtask

    task automatic run_until_idle(input int d, input int limit);
        int k;
        k = 0;
        while (m_mode != 0 && k < limit) begin
            cyc(1'b0, 1'b0, d);
            k++;
        end
        check_bound("reach_idle", m_mode == 0);
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if ({bus.en, bus.busy, bus.wrap, bus.addr} !== '0) begin
            n_fail++;
            $display("FAIL %s: got en=%0b busy=%0b wrap=%0b addr=%0d, required all 0",
                     name, bus.en, bus.busy, bus.wrap, bus.addr);
        end
    endtask

    // Monitor: every sample is compared against the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if ({bus.en, bus.busy, bus.wrap, bus.addr} !== e) begin
                    n_fail++;
                    $display("FAIL seq_out @%0t: got en=%0b busy=%0b wrap=%0b addr=%0d, required en=%0b busy=%0b wrap=%0b addr=%0d",
                             $time, bus.en, bus.busy, bus.wrap, bus.addr,
                             e[AW+2], e[AW+1], e[AW], e[AW-1:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (finished=0, required=1)");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        bus.div   = '0;
        #3;
        check_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        check_zero("reset_held_start_ignored");
        bus.start = 1'b0;
        rst = 1'b0;

        // div=0: one step per cycle, wrap every 256 cycles
        cyc(1'b1, 1'b0, 0);
        repeat (600) cyc(1'b0, 1'b0, 0);

        // div=3 reloads at the next wrap, then 4-cycle steps
        repeat (256 + 1100) cyc(1'b0, 1'b0, 3);

        // change to div=1 mid-period at addr=100
        run_until_addr(100, 3, 2000);
        repeat (1100 + 600) cyc(1'b0, 1'b0, 1);

        // stop pulse at addr 37 drains to the wrap
        run_until_addr(37, 1, 2000);
        cyc(1'b0, 1'b1, 1);
        run_until_idle(1, 2000);
        repeat (10) cyc(1'b0, 1'b1, 1);
        repeat (10) cyc(1'b0, 1'b0, 1);

        // stop at 10, start at 50 while draining: no gap
        cyc(1'b1, 1'b0, 0);
        run_until_addr(10, 0, 600);
        cyc(1'b0, 1'b1, 0);
        run_until_addr(50, 0, 600);
        cyc(1'b1, 1'b0, 0);
        repeat (400) cyc(1'b0, 1'b0, 0);

        // start and stop together in RUN: stop wins
        cyc(1'b1, 1'b1, 0);
        run_until_idle(0, 600);
        repeat (5) cyc(1'b0, 1'b0, 0);

        // asynchronous reset mid-step at addr=200
        cyc(1'b1, 1'b0, 3);
        run_until_addr(200, 3, 2000);
        while (m_t % 4 != 2) cyc(1'b0, 1'b0, 3);
        #2;
        bus.start = 1'b1;
        rst = 1'b1;
        #1;
        check_zero("async_reset_immediate");
        exp_q.delete();
        m_mode = 0;
        m_t    = 0;
        m_dq   = 0;
        repeat (3) begin
            @(negedge clk);
            exp_q.push_back('0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        exp_q.push_back(model_step(1'b0, 1'b0, 3));
        repeat (10) cyc(1'b0, 1'b0, 3);

        // randomized control traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            int d;
            r = int'($urandom_range(0, 99));
            d = int'($urandom_range(0, 2));
            cyc(r < 3, (r >= 3 && r < 5), d);
        end
        repeat (3) cyc(1'b0, 1'b0, 0);

        @(posedge clk);
        #3;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
